// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered address decoder.
// Decode modes, buffer states and payload width helper.
package decoder_pkg;

  localparam logic DEC_ONEHOT = 1'b0;
  localparam logic DEC_THERM  = 1'b1;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Payload is {F, addr, err}.
  function automatic int payload_w(int aw, int ow);
    return ow + aw + 1;
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational (addr, mode) -> {F, err} mapping.
// One compare per output bit; bit 0 optionally hard-zeroed.
module decode_core
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int OUT_W     = 8,
  parameter int MASK_ZERO = 0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              mode,
  output logic [OUT_W-1:0]  f,
  output logic              err
);

  // Out-of-range addresses decode to zero in both modes.
  always_comb begin
    f   = '0;
    err = (int'(addr) >= OUT_W);
    for (int j = 0; j < OUT_W; j++) begin
      if (!err) begin
        if (mode == DEC_THERM)
          f[j] = (j <= int'(addr));
        else
          f[j] = (j == int'(addr));
      end
    end
    if (MASK_ZERO != 0)
      f[0] = 1'b0;
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with valid/ready handshake and skid buffer.
// M drives the outputs, S absorbs the one request taken during a stall.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 3,
  parameter int OUT_W     = 8,
  parameter int MASK_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_F,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam int PW = payload_w(ADDR_W, OUT_W);

  logic [OUT_W-1:0] dec_f;
  logic             dec_err;
  logic [PW-1:0]    new_p;
  logic [PW-1:0]    m_d, m_q;
  logic [PW-1:0]    s_d, s_q;
  buf_state_e       state_d, state_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             in_xfer, out_xfer;

  decode_core #(
    .ADDR_W   (ADDR_W),
    .OUT_W    (OUT_W),
    .MASK_ZERO(MASK_ZERO)
  ) u_core (
    .addr(in_addr),
    .mode(in_mode),
    .f   (dec_f),
    .err (dec_err)
  );

  assign new_p    = {dec_f, in_addr, dec_err};
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next state of the two-entry buffer; ready/valid follow state only.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          m_d     = new_p;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          m_d = new_p;
        end else if (in_xfer) begin
          s_d     = new_p;
          state_d = BUF_TWO;
        end else if (out_xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_xfer) begin
          m_d     = s_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d  = (state_d != BUF_TWO);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  // State, payload registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_F     = m_q[PW-1 -: OUT_W];
  assign out_addr  = m_q[ADDR_W:1];
  assign out_err   = m_q[0];

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: three parameterisations
// share one stimulus stream; table, directed and random phases.
module tb_decoder_pipe;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_addr;
  logic       in_mode;
  logic       out_ready;

  logic       rdy_a, rdy_b, rdy_c;
  logic       vld_a, vld_b, vld_c;
  logic [7:0] f_a, f_c;
  logic [5:0] f_b;
  logic [2:0] ad_a, ad_b, ad_c;
  logic       er_a, er_b, er_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_pipe u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_a),
    .in_addr(in_addr), .in_mode(in_mode),
    .out_valid(vld_a), .out_ready(out_ready),
    .out_F(f_a), .out_addr(ad_a), .out_err(er_a)
  );

  decoder_pipe #(.OUT_W(6)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_b),
    .in_addr(in_addr), .in_mode(in_mode),
    .out_valid(vld_b), .out_ready(out_ready),
    .out_F(f_b), .out_addr(ad_b), .out_err(er_b)
  );

  decoder_pipe #(.MASK_ZERO(1)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_c),
    .in_addr(in_addr), .in_mode(in_mode),
    .out_valid(vld_c), .out_ready(out_ready),
    .out_F(f_c), .out_addr(ad_c), .out_err(er_c)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the rules: returns {err, F} for one instance.
  function automatic logic [8:0] ref_dec(int a, bit m, int ow, bit mz);
    int f;
    bit e;
    e = (a >= ow);
    if (e)      f = 0;
    else if (m) f = (1 << (a + 1)) - 1;
    else        f = 1 << a;
    if (mz) f = f & ~1;
    return {e, 8'(f)};
  endfunction

  task automatic check_out(int a, bit m);
    logic [8:0] e;
    e = ref_dec(a, m, 8, 0);
    chk("F_def", {24'd0, f_a}, {24'd0, e[7:0]});
    chk("err_def", {31'd0, er_a}, {31'd0, e[8]});
    chk("addr_def", {29'd0, ad_a}, a);
    e = ref_dec(a, m, 6, 0);
    chk("F_w6", {26'd0, f_b}, {24'd0, e[7:0]});
    chk("err_w6", {31'd0, er_b}, {31'd0, e[8]});
    chk("addr_w6", {29'd0, ad_b}, a);
    e = ref_dec(a, m, 8, 1);
    chk("F_mask", {24'd0, f_c}, {24'd0, e[7:0]});
    chk("err_mask", {31'd0, er_c}, {31'd0, e[8]});
  endtask

  typedef struct {int a; bit m;} req_t;
  req_t q[$];

  // One cycle against the FIFO model: drive at negedge, check, update.
  task automatic step(bit v, int a, bit m, bit r);
    int sz;
    @(negedge clk);
    in_valid  = v;
    in_addr   = 3'(a);
    in_mode   = m;
    out_ready = r;
    #1;
    sz = q.size();
    chk("in_ready", {31'd0, rdy_a}, {31'd0, sz < 2});
    chk("in_ready_w6", {31'd0, rdy_b}, {31'd0, sz < 2});
    chk("in_ready_mask", {31'd0, rdy_c}, {31'd0, sz < 2});
    chk("out_valid", {31'd0, vld_a}, {31'd0, sz > 0});
    if (sz > 0) check_out(q[0].a, q[0].m);
    if (sz > 0 && r) void'(q.pop_front());
    if (v && sz < 2) q.push_back('{a, m});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, rdy_a}, 1);
    chk("rst_out_valid", {31'd0, vld_a}, 0);
    chk("rst_F", {24'd0, f_a}, 0);
    chk("rst_addr", {29'd0, ad_a}, 0);
    chk("rst_err", {31'd0, er_a}, 0);
    rst = 1'b0;
    q.delete();
  endtask

  typedef struct {
    int         a;
    bit         m;
    logic [7:0] f8;
    logic [7:0] f6;
    bit         e6;
    logic [7:0] fm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_mode = 1'b0;
    out_ready = 1'b1;

    tbl[0]  = '{0, 0, 8'h01, 8'h01, 0, 8'h00};
    tbl[1]  = '{1, 0, 8'h02, 8'h02, 0, 8'h02};
    tbl[2]  = '{2, 0, 8'h04, 8'h04, 0, 8'h04};
    tbl[3]  = '{3, 0, 8'h08, 8'h08, 0, 8'h08};
    tbl[4]  = '{4, 0, 8'h10, 8'h10, 0, 8'h10};
    tbl[5]  = '{5, 0, 8'h20, 8'h20, 0, 8'h20};
    tbl[6]  = '{6, 0, 8'h40, 8'h00, 1, 8'h40};
    tbl[7]  = '{7, 0, 8'h80, 8'h00, 1, 8'h80};
    tbl[8]  = '{3, 1, 8'h0F, 8'h0F, 0, 8'h0E};
    tbl[9]  = '{7, 1, 8'hFF, 8'h00, 1, 8'hFE};
    tbl[10] = '{2, 1, 8'h07, 8'h07, 0, 8'h06};
    tbl[11] = '{5, 0, 8'h20, 8'h20, 0, 8'h20};
    tbl[12] = '{5, 1, 8'h3F, 8'h3F, 0, 8'h3E};
    tbl[13] = '{0, 1, 8'h01, 8'h01, 0, 8'h00};
    tbl[14] = '{6, 1, 8'h7F, 8'h00, 1, 8'h7E};

    do_reset();

    // Back-to-back table stream, out_ready held high.
    for (int i = 0; i <= 15; i++) begin
      @(negedge clk);
      chk("tbl_in_ready", {31'd0, rdy_a}, 1);
      if (i > 0) begin
        chk("tbl_valid", {31'd0, vld_a}, 1);
        chk("tbl_F", {24'd0, f_a}, {24'd0, tbl[i-1].f8});
        chk("tbl_err", {31'd0, er_a}, 0);
        chk("tbl_F_w6", {26'd0, f_b}, {24'd0, tbl[i-1].f6});
        chk("tbl_err_w6", {31'd0, er_b}, {31'd0, tbl[i-1].e6});
        chk("tbl_F_mask", {24'd0, f_c}, {24'd0, tbl[i-1].fm});
        chk("tbl_err_mask", {31'd0, er_c}, 0);
      end
      if (i < 15) begin
        in_valid = 1'b1;
        in_addr  = 3'(tbl[i].a);
        in_mode  = tbl[i].m;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("tbl_drained", {31'd0, vld_a}, 0);

    // Backpressure: send 1, 2, 3 with out_ready low.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = DEC_ONEHOT;
    in_addr = 3'd1;
    @(negedge clk);
    chk("bp_rdy1", {31'd0, rdy_a}, 1);
    chk("bp_F1", {24'd0, f_a}, 8'h02);
    in_addr = 3'd2;
    @(negedge clk);
    chk("bp_rdy_drop", {31'd0, rdy_a}, 0);
    chk("bp_hold", {24'd0, f_a}, 8'h02);
    in_addr = 3'd3;
    @(negedge clk);
    chk("bp_rdy_low", {31'd0, rdy_a}, 0);
    chk("bp_stable", {24'd0, f_a}, 8'h02);
    chk("bp_stable_valid", {31'd0, vld_a}, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out2", {24'd0, f_a}, 8'h04);
    chk("bp_rdy_back", {31'd0, rdy_a}, 1);
    @(negedge clk);
    chk("bp_out3", {24'd0, f_a}, 8'h08);
    chk("bp_valid3", {31'd0, vld_a}, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", {31'd0, vld_a}, 0);

    // Reset while in TWO.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_addr = 3'd1;
    @(negedge clk);
    in_addr = 3'd2;
    @(negedge clk);
    chk("two_rdy", {31'd0, rdy_a}, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("two_rst_valid", {31'd0, vld_a}, 0);
    chk("two_rst_rdy", {31'd0, rdy_a}, 1);
    chk("two_rst_F", {24'd0, f_a}, 0);
    chk("two_rst_addr", {29'd0, ad_a}, 0);
    chk("two_rst_err", {31'd0, er_a}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_addr = 3'd4;
    in_mode = DEC_THERM;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, vld_a}, 1);
    chk("post_rst_F", {24'd0, f_a}, 8'h1F);
    in_valid = 1'b0;
    @(negedge clk);
    q.delete();

    // Random traffic against the FIFO reference model.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, int'($urandom % 8),
           bit'($urandom % 2), ($urandom % 3) != 0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 0, 1'b0, 1'b1);
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered successor to the processor's 3-to-8 address decoder. Accepts an address plus a decode mode over a valid/ready handshake and produces a registered one-hot or thermometer vector one cycle later. A two-entry skid buffer lets the output stall without losing an accepted request. Typical uses are register-file write-strobe generation and bank select in the multicycle datapath, with optional hard-zero masking of index 0 (x0).

## Interface
Parameters:
- `ADDR_W`, default 3: address width.
- `OUT_W`, default 8: decoded vector width. Must satisfy 1 ≤ `OUT_W` ≤ 2**`ADDR_W`.
- `MASK_ZERO`, default 0: when 1, bit 0 of every decoded vector is forced to 0.

Ports:
- `clk`, input, 1: rising-edge clock. This is the block's only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
- `in_addr`, input, `ADDR_W`: address to decode.
- `in_mode`, input, 1: decode mode. 0 = one-hot, 1 = thermometer.
- `out_valid`, output, 1: `out_F`, `out_addr` and `out_err` hold a valid result.
- `out_ready`, input, 1: downstream consumes the result.
- `out_F`, output, `OUT_W`: decoded vector.
- `out_addr`, output, `ADDR_W`: address that produced `out_F`.
- `out_err`, output, 1: `out_addr` ≥ `OUT_W`.

## Operation
Decode rule, evaluated at accept time, with `a` = `in_addr`:
- Out of range (`a` ≥ `OUT_W`): F = all zeros and err = 1, in both modes.
- One-hot (`in_mode` = 0): F[j] = 1 only when j == `a`.
- Thermometer (`in_mode` = 1): F[j] = 1 for every j ≤ `a`.
- Masking: when `MASK_ZERO` = 1, F[0] = 0 after the mode rule is applied. With masking, one-hot of `a` = 0 gives all zeros and err = 0.
- The stored payload is {F, `a`, err}. Width is `OUT_W` + `ADDR_W` + 1.

Handshake transfer rules:
- Input transfer: `in_valid` & `in_ready`.
- Output transfer: `out_valid` & `out_ready`.
- Order is strict FIFO. Payloads are never dropped or duplicated.

Buffer: a main register M drives the outputs; a skid register S holds overflow.
- EMPTY (no entries): `in_ready` = 1, `out_valid` = 0. An input transfer loads M and moves to ONE.
- ONE (M full): `in_ready` = 1, `out_valid` = 1.
  - Input transfer and output transfer together: M is replaced by the new payload; state stays ONE.
  - Input transfer only: the new payload goes to S; move to TWO.
  - Output transfer only: move to EMPTY.
- TWO (M and S full): `in_ready` = 0, `out_valid` = 1.
  - Output transfer: M ← S, move to ONE. No input is accepted in that cycle.
- `in_ready` is a registered function of state only. It has no combinational path from `out_ready`.
- Reset in any state, including mid-stall:
  - State returns to EMPTY. Any buffered payloads are discarded.
  - `in_ready` = 1 and `out_valid` = 0.
  - `out_F`, `out_addr` and `out_err` = 0.

## Timing
- Latency: a payload accepted at edge k appears on the outputs after edge k, assuming the buffer was EMPTY, or ONE with an output transfer at edge k.
- Throughput: one result per cycle while `out_ready` = 1.
- Stall: after `out_ready` drops, at most one further input is accepted, and it lands in S.
- Output data is stable while `out_valid` = 1 and `out_ready` = 0.
- A change of `in_mode` between requests takes effect per request. There is no mode state.
- While `in_valid` = 0 there are no side effects. When `out_valid` = 0, M's contents are don't-care except after reset, when they are 0.

## Structure
- Package `decoder_pkg`:
  - Mode constants `DEC_ONEHOT` = 1'b0 and `DEC_THERM` = 1'b1.
  - Localparam helper for the payload width.
- Sub-module `decode_core`: purely combinational mapping of (addr, mode) to {F, err}. It carries the `ADDR_W`, `OUT_W` and `MASK_ZERO` parameters and uses a for-loop compare per output bit.
- `decoder_pipe` instantiates `decode_core` on the input side and holds the state machine and the M/S registers.

## Test plan
- Reset, then one-hot, default parameters, `out_ready` = 1: send addresses 0..7, one per cycle. Require F = 8'h01, 8'h02, …, 8'h80, each one cycle after accept, and `in_ready` held at 1 throughout.
- Thermometer with addr = 3 → F = 8'h0F. Thermometer with addr = 7 → F = 8'hFF. One-hot and thermometer requests interleaved back-to-back must each decode correctly.
- `OUT_W` = 6: addr = 6 or addr = 7 → F = 6'h00 and err = 1. addr = 5 one-hot → 6'h20 and err = 0.
- `MASK_ZERO` = 1: one-hot addr = 0 → F = 8'h00 and err = 0. Thermometer addr = 2 → F = 8'h06.
- Backpressure: hold `out_ready` = 0 while sending addresses 1, 2, 3.
  - Addresses 1 and 2 are accepted; `in_ready` drops after the second.
  - Output holds 8'h02, the result for address 1.
  - Release `out_ready`: results appear in order 8'h02, 8'h04, 8'h08, with no loss.
- Reset asserted in state TWO: on the next cycle `out_valid` = 0, `in_ready` = 1 and `out_F` = 0. A fresh request then decodes normally.
